// File: rtl/det_cofactor_accum_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// det_pkg : constants, state type and helper for the cofactor accumulator
// Rev 1.0
// ----------------------------------------------------------------------------
package det_pkg;

   localparam logic [31:0] FP_ZERO = 32'h0000_0000;
   localparam logic [31:0] FP_1    = 32'h3F80_0000;
   localparam logic [31:0] FP_2    = 32'h4000_0000;
   localparam logic [31:0] FP_3    = 32'h4040_0000;
   localparam logic [31:0] FP_4    = 32'h4080_0000;
   localparam logic [31:0] FP_10   = 32'h4120_0000;
   localparam logic [31:0] M2      = 32'hC000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } state_e;

   // Leading-zero count of a 27-bit mantissa with guard/round/sticky bits.
   function automatic logic [4:0] lzc27(input logic [26:0] v);
      logic [4:0] n;
      logic       found;
      n     = 5'd0;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
         if (!found && v[i]) found = 1'b1;
         else if (!found)    n = n + 5'd1;
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/det_cofactor_accum_fpu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Mul / Addition_Subtraction : single-precision units, round-to-nearest-even,
// subnormals flushed to zero. Rev 1.0
// ----------------------------------------------------------------------------
module Mul (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] y_o
);
   logic              sgn, a_spec, b_spec, a_zero, b_zero, a_nan, b_nan;
   logic [47:0]       prod;
   logic signed [9:0] exp_s, exp_r;
   logic [23:0]       mant;
   logic              guard, sticky, rnd;
   logic [24:0]       mant_r;
   logic [22:0]       frac;

   always_comb begin
      sgn    = a_i[31] ^ b_i[31];
      a_spec = &a_i[30:23];
      b_spec = &b_i[30:23];
      a_zero = (a_i[30:23] == 8'd0);
      b_zero = (b_i[30:23] == 8'd0);
      a_nan  = a_spec && (a_i[22:0] != 23'd0);
      b_nan  = b_spec && (b_i[22:0] != 23'd0);
      prod   = {1'b1, a_i[22:0]} * {1'b1, b_i[22:0]};
      exp_s  = 10'(a_i[30:23]) + 10'(b_i[30:23]) - 10'sd127;
      if (prod[47]) begin
         mant   = prod[47:24];
         guard  = prod[23];
         sticky = |prod[22:0];
         exp_s  = exp_s + 10'sd1;
      end else begin
         mant   = prod[46:23];
         guard  = prod[22];
         sticky = |prod[21:0];
      end
      rnd    = guard & (sticky | mant[0]);
      mant_r = {1'b0, mant} + {24'd0, rnd};
      exp_r  = mant_r[24] ? exp_s + 10'sd1 : exp_s;
      frac   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

      if (a_spec || b_spec)
         y_o = {sgn, 8'hFF, (a_nan || b_nan || (a_spec && b_zero) || (b_spec && a_zero))
                            ? 23'h40_0000 : 23'd0};
      else if (a_zero || b_zero)
         y_o = {sgn, 31'd0};
      else if (exp_r >= 10'sd255)
         y_o = {sgn, 8'hFF, 23'd0};
      else if (exp_r <= 10'sd0)
         y_o = {sgn, 31'd0};
      else
         y_o = {sgn, exp_r[7:0], frac};
   end
endmodule

module Addition_Subtraction
   import det_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        sub_i,
   output logic [31:0] y_o,
   output logic        exc_o
);
   logic [31:0]       bb, big, sml;
   logic [7:0]        ed;
   logic [26:0]       mb_ext, sh, diff, m;
   logic [27:0]       sum;
   logic [4:0]        lz;
   logic signed [9:0] e;
   logic              eff_sub, rnd;
   logic [24:0]       mr;
   logic [22:0]       frac;

   always_comb begin
      bb = {b_i[31] ^ sub_i, b_i[30:0]};
      if (bb[30:0] > a_i[30:0]) begin
         big = bb;
         sml = a_i;
      end else begin
         big = a_i;
         sml = bb;
      end
      ed      = big[30:23] - sml[30:23];
      mb_ext  = {1'b1, sml[22:0], 3'b000};
      // Alignment keeps every shifted-out bit in the sticky position.
      if (ed >= 8'd27) sh = 27'd1;
      else             sh = (mb_ext >> ed) | {26'd0, |(mb_ext & ((27'd1 << ed) - 27'd1))};
      eff_sub = big[31] ^ sml[31];
      sum     = {1'b0, 1'b1, big[22:0], 3'b000} + {1'b0, sh};
      diff    = {1'b1, big[22:0], 3'b000} - sh;
      lz      = lzc27(diff);
      e       = 10'(big[30:23]);
      if (!eff_sub) begin
         if (sum[27]) begin
            m = {sum[27:2], sum[1] | sum[0]};
            e = e + 10'sd1;
         end else begin
            m = sum[26:0];
         end
      end else begin
         m = diff << lz;
         e = e - $signed(10'(lz));
      end
      rnd  = m[2] & (m[1] | m[0] | m[3]);
      mr   = {1'b0, m[26:3]} + {24'd0, rnd};
      if (mr[24]) e = e + 10'sd1;
      frac = mr[24] ? mr[23:1] : mr[22:0];

      exc_o = 1'b0;
      if (&a_i[30:23] || &bb[30:23]) begin
         exc_o = 1'b1;
         y_o   = (&a_i[30:23]) ? a_i : bb;
      end else if (a_i[30:23] == 8'd0 && bb[30:23] == 8'd0)
         y_o = {a_i[31] & bb[31], 31'd0};
      else if (a_i[30:23] == 8'd0)
         y_o = bb;
      else if (bb[30:23] == 8'd0)
         y_o = a_i;
      else if (eff_sub && diff == 27'd0)
         y_o = FP_ZERO;
      else if (e >= 10'sd255) begin
         exc_o = 1'b1;
         y_o   = {big[31], 8'hFF, 23'd0};
      end else if (e <= 10'sd0)
         y_o = {big[31], 31'd0};
      else
         y_o = {big[31], e[7:0], frac};
   end
endmodule
`default_nettype wire

// File: rtl/det_cofactor_accum.sv
`default_nettype none
// ----------------------------------------------------------------------------
// det_cofactor_accum : streamed (element x cofactor) products accumulated with
// alternating or uniform sign through one multiplier and one adder. Rev 1.0
// ----------------------------------------------------------------------------
module det_cofactor_accum
   import det_pkg::*;
#(
   parameter  int N     = 4,
   localparam int CNT_W = $clog2(N + 1)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_d,
   input  logic        mode_alt,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        det_zero,
   output logic        exc
);
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mode_q, mode_d;
   logic [31:0]      p_q, acc_q, prod, sum;
   logic             p_sub_q, p_last_q, p_vld_q, done_q, exc_q;
   logic             accept, mode_eff, last_pair, add_exc;

   assign in_ready  = (state_q == RUN);
   assign accept    = in_valid && in_ready;
   assign last_pair = (cnt_q == CNT_W'(N - 1));
   // The first pair of a vector takes the live mode; later pairs use the latched copy.
   assign mode_eff  = (cnt_q == '0) ? mode_alt : mode_q;

   Mul u_mul (
      .a_i (in_a),
      .b_i (in_d),
      .y_o (prod)
   );

   Addition_Subtraction u_add (
      .a_i   (acc_q),
      .b_i   (p_q),
      .sub_i (p_sub_q),
      .y_o   (sum),
      .exc_o (add_exc)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      case (state_q)
         IDLE:  state_d = RUN;
         RUN: begin
            if (accept) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == '0) mode_d = mode_alt;
               if (last_pair)   state_d = DRAIN;
            end
         end
         DRAIN: if (done_q) state_d = HOLD;
         HOLD: begin
            if (out_ready) begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         mode_q   <= 1'b0;
         p_q      <= FP_ZERO;
         p_sub_q  <= 1'b0;
         p_last_q <= 1'b0;
         p_vld_q  <= 1'b0;
         done_q   <= 1'b0;
         acc_q    <= FP_ZERO;
         exc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         p_vld_q <= accept;
         done_q  <= p_vld_q && p_last_q;
         if (accept) begin
            p_q      <= prod;
            p_sub_q  <= mode_eff && cnt_q[0];
            p_last_q <= last_pair;
         end
         if (state_q == HOLD && out_ready) begin
            acc_q <= FP_ZERO;
            exc_q <= 1'b0;
         end else if (p_vld_q) begin
            acc_q <= sum;
            exc_q <= exc_q | add_exc;
         end
      end
   end

   assign out_valid = (state_q == HOLD);
   assign result    = acc_q;
   assign det_zero  = out_valid && (acc_q[30:0] == 31'd0);
   assign exc       = exc_q;

endmodule
`default_nettype wire

// File: tb/tb_det_cofactor_accum.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_det_cofactor_accum : directed and random vectors against an exact
// integer model of the signed dot product. Rev 1.0
// ----------------------------------------------------------------------------
module tb_det_cofactor_accum;
   import det_pkg::*;

   localparam logic [31:0] FP_INF = 32'h7F80_0000;
   localparam logic [31:0] FP_8   = 32'h4100_0000;

   logic        clk, rst_n;
   logic        in_valid, in_ready, mode_alt, out_valid, out_ready, det_zero, exc;
   logic [31:0] in_a, in_d, result;
   logic        in2_valid, in2_ready, mode2, out2_valid, out2_ready, det2_zero, exc2;
   logic [31:0] in2_a, in2_d, result2;

   int total = 0;
   int bad   = 0;
   logic [31:0] va [4];
   logic [31:0] vd [4];

   det_cofactor_accum #(.N(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_d(in_d), .mode_alt(mode_alt), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .det_zero(det_zero), .exc(exc)
   );

   det_cofactor_accum #(.N(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in2_valid), .in_ready(in2_ready),
      .in_a(in2_a), .in_d(in2_d), .mode_alt(mode2), .out_valid(out2_valid),
      .out_ready(out2_ready), .result(result2), .det_zero(det2_zero), .exc(exc2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Exact integer -> single conversion (magnitudes stay well below 2^24).
   function automatic logic [31:0] int2fp(input int v);
      int unsigned mag;
      int          msb;
      logic [31:0] r;
      if (v == 0) return 32'h0;
      mag = (v < 0) ? -v : v;
      msb = 0;
      for (int i = 0; i < 31; i++) if (mag[i]) msb = i;
      r[31]    = (v < 0);
      r[30:23] = 8'(127 + msb);
      r[22:0]  = 23'((mag << (23 - msb)) & 32'h007F_FFFF);
      return r;
   endfunction

   task automatic put(input logic [31:0] a, input logic [31:0] d, input logic m);
      logic r;
      bit   ok;
      in_valid = 1'b1; in_a = a; in_d = d; mode_alt = m; ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         r = in_ready;
         @(posedge clk); #1;
         ok = r;
      end
      chk("accept", 32'(ok), 1);
   endtask

   task automatic put2(input logic [31:0] a, input logic [31:0] d, input logic m);
      logic r;
      bit   ok;
      in2_valid = 1'b1; in2_a = a; in2_d = d; mode2 = m; ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         r = in2_ready;
         @(posedge clk); #1;
         ok = r;
      end
      chk("accept2", 32'(ok), 1);
   endtask

   task automatic feed4(input logic [31:0] a [4], input logic [31:0] d [4],
                        input logic m0, input logic m1, input bit gaps);
      for (int i = 0; i < 4; i++) begin
         put(a[i], d[i], (i == 0) ? m0 : m1);
         if (gaps && i < 3) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
      end
      in_valid = 1'b0;
      chk("lat0", out_valid, 0);
      @(posedge clk); #1;
      chk("lat1", out_valid, 0);
      @(posedge clk); #1;
      chk("lat2", out_valid, 1);
   endtask

   task automatic expect_out(input string tag, input logic [31:0] res, input logic e);
      chk({tag, "_result"}, result, res);
      chk({tag, "_det_zero"}, det_zero, (res[30:0] == 31'd0));
      chk({tag, "_exc"}, exc, e);
      chk({tag, "_in_ready"}, in_ready, 0);
   endtask

   task automatic ack();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("ack_out_valid", out_valid, 0);
      chk("ack_in_ready", in_ready, 1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_result"}, result, 0);
      chk({tag, "_det_zero"}, det_zero, 0);
      chk({tag, "_exc"}, exc, 0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_d = '0; mode_alt = 1'b0; out_ready = 1'b0;
      in2_valid = 1'b0; in2_a = '0; in2_d = '0; mode2 = 1'b0; out2_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset("rst");
      chk("rst_out2_valid", out2_valid, 0);
      chk("rst_in2_ready", in2_ready, 0);
      rst_n = 1'b1;
      chk("rel_in_ready0", in_ready, 0);
      @(posedge clk); #1;
      chk("rel_in_ready1", in_ready, 1);

      // Alternating sign: 1-2+3-4 = -2
      va = '{FP_1, FP_2, FP_3, FP_4};
      vd = '{FP_1, FP_1, FP_1, FP_1};
      feed4(va, vd, 1'b1, 1'b1, 1'b0);
      expect_out("alt", M2, 1'b0);
      ack();

      // Uniform sign: 10
      feed4(va, vd, 1'b0, 1'b0, 1'b0);
      expect_out("dot", FP_10, 1'b0);
      ack();

      // Cancellation to zero
      va = '{FP_1, FP_1, FP_1, FP_1};
      feed4(va, vd, 1'b1, 1'b1, 1'b0);
      expect_out("zero", FP_ZERO, 1'b0);
      ack();

      // Mid-vector mode toggles are ignored
      va = '{FP_1, FP_2, FP_3, FP_4};
      feed4(va, vd, 1'b1, 1'b0, 1'b0);
      expect_out("tog10", M2, 1'b0);
      ack();
      feed4(va, vd, 1'b0, 1'b1, 1'b0);
      expect_out("tog01", FP_10, 1'b0);
      ack();

      // Output backpressure with a new pair waiting on the input
      feed4(va, vd, 1'b1, 1'b1, 1'b0);
      expect_out("bp", M2, 1'b0);
      in_valid = 1'b1; in_a = FP_1; in_d = FP_1; mode_alt = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("bp_out_valid", out_valid, 1);
         chk("bp_result", result, M2);
         chk("bp_in_ready", in_ready, 0);
      end
      ack();
      feed4(va, vd, 1'b0, 1'b0, 1'b0);
      expect_out("bp_next", FP_10, 1'b0);
      ack();

      // Input bubbles
      feed4(va, vd, 1'b1, 1'b1, 1'b1);
      expect_out("gaps", M2, 1'b0);
      ack();

      // Reset mid-vector
      put(va[0], vd[0], 1'b1);
      put(va[1], vd[1], 1'b1);
      in_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk_reset("mid_rst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("mid_rel_in_ready0", in_ready, 0);
      @(posedge clk); #1;
      chk("mid_rel_in_ready1", in_ready, 1);
      feed4(va, vd, 1'b1, 1'b1, 1'b0);
      expect_out("post_rst", M2, 1'b0);
      ack();

      // Infinite element raises the sticky exception, cleared on the next vector
      va = '{FP_INF, FP_1, FP_1, FP_1};
      feed4(va, vd, 1'b0, 1'b0, 1'b0);
      expect_out("inf", FP_INF, 1'b1);
      ack();
      va = '{FP_1, FP_2, FP_3, FP_4};
      feed4(va, vd, 1'b0, 1'b0, 1'b0);
      expect_out("inf_clr", FP_10, 1'b0);
      ack();

      // Random integer-valued vectors against an exact integer model
      for (int t = 0; t < 20; t++) begin
         int   s;
         logic m0, m1;
         bit   g;
         m0 = 1'($urandom_range(1));
         m1 = 1'($urandom_range(1));
         g  = 1'($urandom_range(1));
         s  = 0;
         for (int i = 0; i < 4; i++) begin
            int ai, di;
            ai = int'($urandom_range(100)) - 50;
            di = int'($urandom_range(100)) - 50;
            va[i] = int2fp(ai);
            vd[i] = int2fp(di);
            s += (m0 && (i % 2 == 1)) ? -(ai * di) : (ai * di);
         end
         feed4(va, vd, m0, m1, g);
         expect_out("rnd", int2fp(s), 1'b0);
         ack();
      end

      // Two-pair instance: 3*2 - 2*1 = 4, then 3*2 + 2*1 = 8
      for (int v = 0; v < 2; v++) begin
         logic [31:0] exp2;
         exp2 = (v == 0) ? FP_4 : FP_8;
         put2(FP_3, FP_2, (v == 0));
         put2(FP_2, FP_1, 1'b0);
         in2_valid = 1'b0;
         for (int k = 0; k < 10 && !out2_valid; k++) begin
            @(posedge clk); #1;
         end
         chk("n2_out_valid", out2_valid, 1);
         chk("n2_result", result2, exp2);
         chk("n2_det_zero", det2_zero, 0);
         chk("n2_exc", exc2, 0);
         out2_ready = 1'b1;
         @(posedge clk); #1;
         out2_ready = 1'b0;
         chk("n2_ack_out_valid", out2_valid, 0);
         chk("n2_ack_in_ready", in2_ready, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/det_cofactor_accum.md
Name: det_cofactor_accum

Overview:
- Sequential, parametrised cofactor-expansion engine for IEEE-754 single-precision values.
- Accepts N (element, cofactor) pairs over a valid/ready stream and multiplies each pair.
- Accumulates the products with alternating sign (determinant row expansion) or uniform sign (dot product).
- Presents one result per vector with a zero flag and an exception flag.
- Replaces the fixed 4-term combinational expansion in the matrix-divider datapath. It uses one shared multiplier and one shared adder, for any row length.

Parameters:
- N, 4, pairs per vector; legal 2..16.
- CNT_W, $clog2(N+1), element counter width (derived, not overridden).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  pair valid
- in_ready  out  1  pair accepted when in_valid && in_ready
- in_a  in  32  matrix element, IEEE-754 single
- in_d  in  32  cofactor, IEEE-754 single
- mode_alt  in  1  1 = alternating sign (+,-,+,-...), 0 = all positive; sampled on the first accept of each vector
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- result  out  32  accumulated sum, IEEE-754 single
- det_zero  out  1  result magnitude is zero (+0 or -0)
- exc  out  1  sticky per vector: any adder Exception during this vector

Behaviour:
- Reset is asynchronous on rst_n low; any operation in progress is discarded. Reset values:
  - in_ready=0 for one cycle after release, then 1.
  - out_valid=0, result=0, det_zero=0, exc=0.
  - Accumulator=+0, counter=0, pipeline valid bits=0.
- FSM states: IDLE, RUN, DRAIN, HOLD.
  - IDLE: entered from reset. Goes to RUN on the first clock after reset release.
  - RUN: in_ready=1. Each accept increments cnt and launches stage 1. On the accept with cnt==N-1, in_ready deasserts next cycle and the FSM goes to DRAIN.
  - DRAIN: in_ready=0. Waits until the last product has been accumulated, then goes to HOLD.
  - HOLD: out_valid=1. result, det_zero and exc are held stable. On out_ready, goes to RUN next cycle with acc=+0, cnt=0, exc cleared, out_valid=0.
- Stage 1 (product register):
  - p_q <= Mul(in_a, in_d).
  - p_sub <= mode_latched && cnt[0]; index is 0-based, so odd indices subtract.
  - p_last <= (cnt==N-1).
  - p_vld <= accept.
  - On the first accept of a vector, mode_alt is used directly and also latched.
- Stage 2 (accumulate): when p_vld, acc <= Addition_Subtraction(acc, p_q, AddBar_Sub=p_sub). exc |= the adder Exception.
- Latency: out_valid rises 2 cycles after the accept of pair N-1, provided in_valid had no gaps for that pair. Minimum vector period is N+3 cycles including the HOLD handshake.
- Bubbles: in_valid may drop mid-vector. The counter and accumulator hold; there is no timeout.
- mode_alt changes mid-vector are ignored until the next vector.
- det_zero = (result[30:0]==0); both signed zeros are flagged. It is combinational from result and valid only when out_valid.
- in_a/in_d must not be sampled when in_ready=0. A held in_valid during DRAIN/HOLD is accepted only after return to RUN.
- The arithmetic is the IEEE rounding of the shared units, applied sequentially in index order. The accumulation order is part of the spec: the bench compares bit-exactly against the same ordered sum.

Decomposition:
- Package det_pkg holds:
  - FP_ZERO=32'h0000_0000.
  - State enum {IDLE, RUN, DRAIN, HOLD}.
  - Test constants FP_1/2/3/4/10, M2.
- No new sub-module. Instantiate the existing Mul and Addition_Subtraction units once each. The FSM, counter and pipeline registers stay in this module.

Test Plan:
- N=4, mode_alt=1. a={1,2,3,4} (3F800000, 40000000, 40400000, 40800000), d all 3F800000, no bubbles. Required: result=C0000000 (-2.0), det_zero=0, exc=0, out_valid 2 cycles after the 4th accept.
- Same data with mode_alt=0. Required: result=41200000 (10.0), det_zero=0.
- mode_alt=1, a all 3F800000, d all 3F800000. Required: result[30:0]=0, det_zero=1. Then mode_alt toggled mid-next-vector. Required: the toggle is ignored and the sign pattern is unchanged.
- Backpressure: out_ready low 5 cycles. Required: out_valid, result and in_ready=0 stay stable. Release. Required: in_ready=1 next cycle and the next vector is accepted correctly.
- Bubbles plus reset: in_valid toggled every other cycle gives the same result as test 1. rst_n pulled low after 2 accepts. Required: all outputs reset immediately, and the next full vector gives the clean result.
- N=2 instance, mode_alt=1, a={40400000, 40000000}, d={40000000, 3F800000}. Required: result=40800000 (6-2=4.0).
